demux_rr_sched: RTL and testbench
=================================

# demux_rr_sched

Round-robin scheduler that drives the 1-to-8 demultiplexer. It accepts a single-bit input stream with a valid/ready handshake and picks one of eight destination channels by round-robin among the channels that are ready. It then holds that selection for a burst of beats and routes each beat onto the granted channel. It sits between the upstream serial source and the eight channel consumers, and owns the demux `sel` code.

## Interface
- `NUM_CH`, 8: number of output channels; only 8 is supported.
- `SEL_W`, 3: select width, equal to log2(`NUM_CH`).
- `BURST_MAX`, 4: maximum beats per grant, legal range 1..16.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream beat valid.
- `in_data`  in  1  upstream beat data.
- `in_last`  in  1  last beat of the packet; qualified by `in_valid`.
- `in_ready`  out  1  upstream beat accepted when `in_valid & in_ready`.
- `ch_ready`  in  8  per-channel consumer ready.
- `sel`  out  3  registered demux select, equal to the granted channel.
- `out_valid`  out  8  one-hot channel valid.
- `out_data`  out  8  `in_data` on bit `sel` and 0 on all other bits, during XFER only.
- `busy`  out  1  high in GRANT and XFER.

## Operation
- Reset values: `sel`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, state IDLE, round-robin pointer `ptr`=0, beat count `cnt`=0.
- FSM states are IDLE, GRANT and XFER.
- **IDLE**:
  - If `in_valid` is high and at least one eligible channel has `ch_ready` high, register the winner into `sel`, clear `cnt` and go to GRANT.
  - Otherwise stay in IDLE.
- **Winner selection**: the first eligible, ready channel when searching `ptr`, `ptr`+1, … modulo 8. The search wraps from 7 to 0.
- **GRANT**: lasts exactly one cycle. `sel` is stable, and `out_valid`, `out_data` and `in_ready` are all 0. The next state is always XFER.
- **XFER**:
  - `in_ready` = `ch_ready[sel]`.
  - `out_valid[sel]` = `in_valid`; all other `out_valid` bits are 0.
  - `out_data[sel]` = `in_data`; all other `out_data` bits are 0.
  - `out_valid` does not depend on `ch_ready`.
- **Beat accepted** (`in_valid & in_ready`):
  - If `in_last` is high or `cnt` = `BURST_MAX`-1, the burst ends: go to IDLE and set `ptr` = (`sel`+1) mod 8.
  - Otherwise `cnt` increments.
- **Stall**: when `ch_ready[sel]` is low in XFER, the block holds state, `cnt` and `sel`. No timeout applies.
- **Grant stability**: the grant is never revoked mid-burst. Changes on `ch_ready` of other channels have no effect until the next IDLE.
- **Counter width**: `cnt` is 4 bits and is compared against `BURST_MAX`-1. With `BURST_MAX`=1 every accepted beat ends the burst.
- **Reset mid-burst**: all state and outputs return to their reset values immediately. The partial burst is dropped, and the next grant searches from channel 0.

## Timing
- **Acquisition latency**: with `in_valid` and a ready channel sampled at edge N:
  - GRANT is entered after edge N.
  - XFER is entered after edge N+1.
  - The first beat is accepted at the earliest at edge N+2.
- **Streaming**: throughput inside a burst is 1 beat/cycle while `ch_ready[sel]` stays high.
- **Burst turnaround**: after the final beat at edge M, the block is in IDLE during cycle M+1. The earliest next acceptance is edge M+3, giving a minimum of 2 dead cycles between bursts.
- **Combinational paths**: `in_ready`, `out_valid` and `out_data` are combinational from `ch_ready`, `in_valid`, `in_data` and the registered state. `sel` and `busy` are registered.

## Configuration
- With `DEMUX_SCHED_MASK_EN` defined:
  - An extra input port `ch_mask` (in, 8 bits) is added.
  - A channel is eligible only when its `ch_mask` bit is 1.
  - `ch_mask` is sampled only in IDLE; changes during GRANT or XFER do not affect the current grant.
- Without the macro: the port is absent and all 8 channels are always eligible.

## Structure
- Shared package `demux_pkg` holds:
  - the state enum `sched_state_t` (IDLE, GRANT, XFER);
  - the constants `DEMUX_NUM_CH`=8 and `DEMUX_SEL_W`=3.
- Sub-module `rr_pick8`: purely combinational priority search. It takes `req[7:0]` and `ptr[2:0]`, and produces `gnt_idx[2:0]` and `any`.
- The FSM, counter and output routing stay in the top level.

## Test plan
- **Single beat**: after reset, all `ch_ready`=1; one beat `in_data`=1 with `in_last`=1 → `sel`=0, `out_valid`=8'h01 and `out_data`=8'h01 at the acceptance edge, which is 2 cycles after `in_valid` is sampled. `ptr` then becomes 1.
- **Round-robin wrap**: 9 consecutive single-beat packets, all channels ready → `sel` sequence 0,1,2,3,4,5,6,7,0.
- **Burst cap**: `BURST_MAX`=4, a 6-beat packet to ready channels → 4 beats on channel 0, back to IDLE, then 2 beats on channel 1. The `in_last` beat lands on channel 1.
- **Skip and stall**: `ch_ready`=8'b0010_0000 → grant `sel`=5. Dropping `ch_ready[5]` for 3 cycles mid-burst gives `in_ready`=0 with `out_valid`=8'h20 held, and no beat is lost or duplicated.
- **Async reset mid-burst**: pulse `rst_n` low during beat 2 → all outputs are 0 immediately, and the next packet is granted to channel 0.
- **Mask (`DEMUX_SCHED_MASK_EN`)**: `ch_mask`=8'hF0 with all channels ready → grants cycle through 4,5,6,7,4 only.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the round-robin demux scheduler.
// Optional channel masking is enabled in the top level by DEMUX_SCHED_MASK_EN.
package demux_pkg;

    localparam int DEMUX_NUM_CH = 8;
    localparam int DEMUX_SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } sched_state_t;

    // Round-robin successor of a channel index, wrapping 7 -> 0.
    function automatic logic [DEMUX_SEL_W-1:0] next_ch(input logic [DEMUX_SEL_W-1:0] ch);
        return ch + DEMUX_SEL_W'(1);
    endfunction

endpackage

// File: rtl/demux_rr_sched_rr_pick8.sv
// Combinational rotating-priority search over eight requests, starting at ptr.
module rr_pick8
    import demux_pkg::*;
(
    input  logic [DEMUX_NUM_CH-1:0] req,
    input  logic [DEMUX_SEL_W-1:0]  ptr,
    output logic [DEMUX_SEL_W-1:0]  gnt_idx,
    output logic                    any
);

    logic [DEMUX_SEL_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt_idx = ptr;
        idx     = '0;
        any     = |req;
        for (int i = DEMUX_NUM_CH - 1; i >= 0; i--) begin
            idx = ptr + DEMUX_SEL_W'(i);
            if (req[idx]) begin
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler driving a 1-to-8 bit-serial demux with burst grants.
// Define DEMUX_SCHED_MASK_EN to add the ch_mask eligibility input.
module demux_rr_sched
    import demux_pkg::*;
#(
    parameter int NUM_CH    = DEMUX_NUM_CH,
    parameter int SEL_W     = DEMUX_SEL_W,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_data,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [NUM_CH-1:0] ch_ready,
`ifdef DEMUX_SCHED_MASK_EN
    input  logic [NUM_CH-1:0] ch_mask,
`endif
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] out_valid,
    output logic [NUM_CH-1:0] out_data,
    output logic              busy
);

    localparam logic [3:0] CNT_LAST = 4'(BURST_MAX - 1);

    sched_state_t      state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              busy_q;

    logic [NUM_CH-1:0] req;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic              beat_acc;

`ifdef DEMUX_SCHED_MASK_EN
    assign req = ch_ready & ch_mask;
`else
    assign req = ch_ready;
`endif

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Requests are only evaluated in IDLE, so a grant holds for the whole burst.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = '0;
        out_data  = '0;
        beat_acc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && pick_any) begin
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = XFER;
            end
            XFER: begin
                in_ready         = ch_ready[sel_q];
                out_valid[sel_q] = in_valid;
                out_data[sel_q]  = in_data;
                beat_acc         = in_valid & ch_ready[sel_q];
                if (beat_acc) begin
                    if (in_last || (cnt_q == CNT_LAST)) begin
                        state_d = IDLE;
                        ptr_d   = next_ch(sel_q);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_demux_rr_sched.sv
// Scoreboard bench for demux_rr_sched: directed packets, monitor checks each accepted beat.
module tb_demux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_data, in_last;
    logic       in_ready;
    logic [7:0] ch_ready;
`ifdef DEMUX_SCHED_MASK_EN
    logic [7:0] ch_mask;
`endif
    logic [2:0] sel;
    logic [7:0] out_valid, out_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   ch;
        logic d;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    demux_rr_sched #(.BURST_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ch_ready  (ch_ready),
`ifdef DEMUX_SCHED_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: sel=%0d out_valid=0x%0h expected no beat", sel, out_valid);
            end else begin
                exp_t       e;
                logic [7:0] ev;
                e  = exp_q.pop_front();
                ev = 8'h01 << e.ch;
                check("beat_sel", 32'(sel), 32'(e.ch));
                check("beat_out_valid", 32'(out_valid), 32'(ev));
                check("beat_out_data", 32'(out_data), e.d ? 32'(ev) : 32'h0);
            end
        end
    end

    // Presents one beat and holds it until accepted; waits = cycles spent unaccepted.
    task automatic send_beat(input logic d, input logic l, input int exp_ch, output int waits);
        logic acc;
        exp_t e;
        e.ch = exp_ch;
        e.d  = d;
        exp_q.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        acc      = 1'b0;
        waits    = 0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: beat for ch %0d not accepted in 40 cycles", exp_ch);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 1'b0;
        in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        logic bits6[6];
        int   ch6[6];
        ch_ready = 8'hFF;
`ifdef DEMUX_SCHED_MASK_EN
        ch_mask = 8'hFF;
`endif
        do_reset();

        check("rst_sel", 32'(sel), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Single beat: two unaccepted cycles (IDLE, GRANT) then accept on channel 0.
        send_beat(1'b1, 1'b1, 0, w);
        check("single_latency", 32'(w), 32'd2);
        check("single_busy_after", 32'(busy), 32'h0);
        // ptr=1 shows up as the next grant.
        send_beat(1'b0, 1'b1, 1, w);
        check("single_next_ptr", 32'(w), 32'd2);

        // Round-robin wrap from reset: 0..7,0.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            send_beat(1'(k & 1), 1'b1, k % 8, w);
            check("rr_turnaround", 32'(w), 32'd2);
        end

        // Burst cap: 6-beat packet split 4 on ch0 and 2 on ch1.
        do_reset();
        bits6 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        ch6   = '{0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 6; k++) begin
            send_beat(bits6[k], k == 5, ch6[k], w);
            if (k == 4) check("cap_regrant_wait", 32'(w), 32'd2);
            else if (k != 0) check("cap_stream_wait", 32'(w), 32'd0);
        end

        // Skip to the only ready channel, then stall it while others become ready.
        ch_ready = 8'b0010_0000;
        send_beat(1'b0, 1'b0, 5, w);
        ch_ready = 8'h0F;
        in_valid = 1'b1;
        in_data  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_out_valid", 32'(out_valid), 32'h20);
            check("stall_out_data", 32'(out_data), 32'h20);
            check("stall_sel", 32'(sel), 32'd5);
            @(posedge clk);
            #1;
        end
        ch_ready = 8'b0010_0000;
        send_beat(1'b1, 1'b0, 5, w);
        check("stall_resume_wait", 32'(w), 32'd0);
        send_beat(1'b0, 1'b1, 5, w);

        // Async reset during beat 2 of a packet to ch6.
        ch_ready = 8'hFF;
        send_beat(1'b1, 1'b0, 6, w);
        in_valid = 1'b1;
        in_data  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel), 32'h0);
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_data", 32'(out_data), 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        #3;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        send_beat(1'b1, 1'b1, 0, w);
        check("arst_regrant_wait", 32'(w), 32'd2);

`ifdef DEMUX_SCHED_MASK_EN
        do_reset();
        ch_mask = 8'hF0;
        for (int k = 0; k < 5; k++) begin
            send_beat(1'b1, 1'b1, 4 + (k % 4), w);
        end
        ch_mask = 8'hFF;
`endif

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
